// File: rtl/reorder_buf_pkg.sv
// Shared types and constants for the reorder buffer: entry layout,
// architectural register type and the active-low enable encoding.
package reorder_buf_pkg;

    localparam int   RobDepth = 16;
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    typedef logic [4:0] RegFile_t;

    typedef struct packed {
        logic     valid;
        logic     done;
        RegFile_t rd;
    } RobEntry_t;

endpackage

// File: rtl/reorder_buf_ptr.sv
// Wrapping pointer for the reorder buffer; rolls over modulo 2**W.
module reorder_buf_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buf.sv
// Circular reorder buffer: allocates at dispatch, marks done on writeback,
// retires strictly in program order, one entry per cycle.
module reorder_buf
    import reorder_buf_pkg::*;
#(
    parameter int ROB_DEPTH = RobDepth,
    parameter int ROB       = $clog2(ROB_DEPTH)
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic           flush_,
    input  logic           dec_e_,
    input  RegFile_t       dec_rd,
    output logic [ROB-1:0] dec_rob_id,
    output logic           busy,
    input  logic           wb_e_,
    input  logic [ROB-1:0] wb_rob_id,
    output logic           commit_e_,
    output RegFile_t       commit_rd,
    output logic [ROB-1:0] commit_rob_id
);

    localparam logic [ROB:0] FullCount = ROB_DEPTH[ROB:0];

    RobEntry_t      entries_q [ROB_DEPTH];
    RobEntry_t      entries_d [ROB_DEPTH];
    logic [ROB:0]   count_q;
    logic [ROB:0]   count_d;
    logic [ROB-1:0] head;
    logic [ROB-1:0] tail;
    logic           flush_act;
    logic           disp_ok;
    logic           commit_ok;

    assign flush_act = (flush_ == Enable_);
    // busy looks only at registered count, so a same-cycle commit never frees a slot
    assign busy      = (count_q == FullCount);
    assign disp_ok   = (dec_e_ == Enable_) && !busy;
    assign commit_ok = entries_q[head].valid && entries_q[head].done;

    assign commit_e_     = commit_ok ? Enable_ : Disable_;
    assign commit_rd     = entries_q[head].rd;
    assign commit_rob_id = head;
    assign dec_rob_id    = tail;

    reorder_buf_ptr #(.W(ROB)) u_head (
        .clk    (clk),
        .reset_ (reset_),
        .clr_i  (flush_act),
        .inc_i  (commit_ok),
        .ptr_o  (head)
    );

    reorder_buf_ptr #(.W(ROB)) u_tail (
        .clk    (clk),
        .reset_ (reset_),
        .clr_i  (flush_act),
        .inc_i  (disp_ok),
        .ptr_o  (tail)
    );

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (flush_act) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
            count_d = '0;
        end else begin
            if ((wb_e_ == Enable_) && entries_q[wb_rob_id].valid) begin
                entries_d[wb_rob_id].done = 1'b1;
            end
            if (commit_ok) begin
                entries_d[head].valid = 1'b0;
            end
            if (disp_ok) begin
                entries_d[tail].valid = 1'b1;
                entries_d[tail].done  = 1'b0;
                entries_d[tail].rd    = dec_rd;
            end
            if (disp_ok && !commit_ok) begin
                count_d = count_q + (ROB+1)'(1);
            end else if (!disp_ok && commit_ok) begin
                count_d = count_q - (ROB+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buf.sv
// Bench for reorder_buf: program-order queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reorder_buf;
    import reorder_buf_pkg::*;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset_;
    logic       flush_;
    logic       dec_e_;
    RegFile_t   dec_rd;
    logic [3:0] dec_rob_id;
    logic       busy;
    logic       wb_e_;
    logic [3:0] wb_rob_id;
    logic       commit_e_;
    RegFile_t   commit_rd;
    logic [3:0] commit_rob_id;

    reorder_buf #(.ROB_DEPTH(D)) dut (
        .clk           (clk),
        .reset_        (reset_),
        .flush_        (flush_),
        .dec_e_        (dec_e_),
        .dec_rd        (dec_rd),
        .dec_rob_id    (dec_rob_id),
        .busy          (busy),
        .wb_e_         (wb_e_),
        .wb_rob_id     (wb_rob_id),
        .commit_e_     (commit_e_),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-flight IDs in program order, last rd written per slot, done flags.
    int       qid[$];
    int       tail_m;
    RegFile_t rd_m   [D];
    bit       done_m [D];
    bit       m_com;
    bit       m_disp;

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            qid.delete();
            tail_m = 0;
            for (int i = 0; i < D; i++) begin
                rd_m[i]   = '0;
                done_m[i] = 1'b0;
            end
        end else if (flush_ == Enable_) begin
            qid.delete();
            tail_m = 0;
        end else begin
            m_com  = (qid.size() > 0) && done_m[qid[0]];
            m_disp = (dec_e_ == Enable_) && (qid.size() < D);
            if (wb_e_ == Enable_) begin
                foreach (qid[k]) if (qid[k] == int'(wb_rob_id)) done_m[qid[k]] = 1'b1;
            end
            if (m_com) void'(qid.pop_front());
            if (m_disp) begin
                qid.push_back(tail_m);
                rd_m[tail_m]   = dec_rd;
                done_m[tail_m] = 1'b0;
                tail_m = (tail_m + 1) % D;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_) begin
            int h;
            int ce;
            h  = (tail_m - qid.size() + D) % D;
            ce = ((qid.size() > 0) && done_m[qid[0]]) ? 0 : 1;
            chk("model_commit_e_", int'(commit_e_), ce);
            chk("model_commit_rob_id", int'(commit_rob_id), h);
            chk("model_commit_rd", int'(commit_rd), int'(rd_m[h]));
            chk("model_dec_rob_id", int'(dec_rob_id), tail_m);
            chk("model_busy", int'(busy), (qid.size() == D) ? 1 : 0);
        end
    end

    task automatic cyc(input logic de, input int rd, input logic we, input int wid, input logic fl);
        dec_e_    = de;
        dec_rd    = RegFile_t'(rd);
        wb_e_     = we;
        wb_rob_id = 4'(wid);
        flush_    = fl;
        @(posedge clk);
        #1;
        dec_e_ = 1'b1;
        wb_e_  = 1'b1;
        flush_ = 1'b1;
    endtask

    task automatic idle();            cyc(1'b1, 0, 1'b1, 0, 1'b1);  endtask
    task automatic disp(input int rd); cyc(1'b0, rd, 1'b1, 0, 1'b1); endtask
    task automatic wb(input int id);   cyc(1'b1, 0, 1'b0, id, 1'b1); endtask
    task automatic flush();            cyc(1'b1, 0, 1'b1, 0, 1'b0);  endtask

    initial begin
        reset_    = 1'b0;
        flush_    = 1'b1;
        dec_e_    = 1'b1;
        dec_rd    = '0;
        wb_e_     = 1'b1;
        wb_rob_id = '0;
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;

        chk("reset_commit_e_", int'(commit_e_), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_dec_rob_id", int'(dec_rob_id), 0);
        chk("reset_commit_rob_id", int'(commit_rob_id), 0);
        chk("reset_commit_rd", int'(commit_rd), 0);

        // Basic
        dec_e_ = 1'b0; dec_rd = 5'd5; #1;
        chk("basic_alloc_id", int'(dec_rob_id), 0);
        disp(5);
        chk("basic_not_done", int'(commit_e_), 1);
        wb(0);
        chk("basic_commit_e_", int'(commit_e_), 0);
        chk("basic_commit_rd", int'(commit_rd), 5);
        chk("basic_commit_id", int'(commit_rob_id), 0);
        idle();
        chk("basic_empty_commit_e_", int'(commit_e_), 1);
        chk("basic_empty_head", int'(commit_rob_id), 1);

        // In-order retirement
        flush();
        disp(7); disp(8); disp(9);
        wb(2);
        chk("inorder_wb2_no_commit", int'(commit_e_), 1);
        wb(1);
        chk("inorder_wb1_no_commit", int'(commit_e_), 1);
        wb(0);
        chk("inorder_c0", int'(commit_e_), 0);
        chk("inorder_c0_id", int'(commit_rob_id), 0);
        idle();
        chk("inorder_c1", int'(commit_e_), 0);
        chk("inorder_c1_rd", int'(commit_rd), 8);
        idle();
        chk("inorder_c2", int'(commit_e_), 0);
        chk("inorder_c2_id", int'(commit_rob_id), 2);
        idle();
        chk("inorder_drained", int'(commit_e_), 1);

        // Full
        flush();
        for (int i = 0; i < D; i++) disp(i + 10);
        chk("full_busy", int'(busy), 1);
        chk("full_tail_wrapped", int'(dec_rob_id), 0);
        disp(30);
        chk("full_17th_ignored_tail", int'(dec_rob_id), 0);
        chk("full_17th_head_rd", int'(commit_rd), 10);
        wb(0);
        chk("full_commit_ready", int'(commit_e_), 0);
        disp(20);
        chk("full_refused_tail", int'(dec_rob_id), 0);
        chk("full_slot_freed", int'(busy), 0);
        disp(20);
        chk("full_accepted_tail", int'(dec_rob_id), 1);
        chk("full_busy_again", int'(busy), 1);

        // Wrap-around
        flush();
        for (int i = 0; i < 40; i++) begin
            chk("wrap_alloc_id", int'(dec_rob_id), i % 16);
            disp(i % 32);
            wb(i % 16);
            chk("wrap_commit_id", int'(commit_rob_id), i % 16);
            chk("wrap_commit_e_", int'(commit_e_), 0);
            idle();
            chk("wrap_not_busy", int'(busy), 0);
        end

        // Flush
        flush();
        for (int i = 0; i < 5; i++) disp(i + 1);
        wb(3); wb(1);
        flush();
        chk("flush_commit_e_", int'(commit_e_), 1);
        chk("flush_tail", int'(dec_rob_id), 0);
        chk("flush_head", int'(commit_rob_id), 0);
        wb(3);
        for (int i = 0; i < 4; i++) disp(i + 20);
        wb(0); wb(1); wb(2);
        idle(); idle();
        chk("flush_stale_wb_ignored", int'(commit_e_), 1);
        chk("flush_head_at_3", int'(commit_rob_id), 3);

        // Async reset mid-cycle
        flush();
        for (int i = 0; i < D; i++) disp(i);
        wb(0);
        chk("areset_pre_commit_e_", int'(commit_e_), 0);
        chk("areset_pre_busy", int'(busy), 1);
        #2 reset_ = 1'b0;
        #1;
        chk("areset_commit_e_", int'(commit_e_), 1);
        chk("areset_busy", int'(busy), 0);
        chk("areset_dec_rob_id", int'(dec_rob_id), 0);
        @(posedge clk);
        #1 reset_ = 1'b1;
        idle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buf.md
# reorder_buf

Circular reorder buffer for the out-of-order core. It sits beside `inst_queue`: it allocates a ROB entry at dispatch and hands the entry ID to rename, which turns it into `TYPE_ROB` destination tags. It marks entries complete on writeback and retires them strictly in program order, driving the `commit_e_`/`commit_rd`/`commit_rob_id` bus that `inst_queue` and the register file consume.

## Interface
- `ROB_DEPTH`, default `` `RobDepth ``: number of entries; must be a power of two, ≥ 2.
- `ROB`, default `$clog2(ROB_DEPTH)`: entry ID width.
- `clk` in 1: the single clock.
- `reset_` in 1: reset. Asynchronous and active-low; clears all state.
- `flush_` in 1: synchronous flush, active-low; discards all entries.
- `dec_e_` in 1: dispatch request, active-low.
- `dec_rd` in `RegFile_t`: architectural destination of the dispatched instruction.
- `dec_rob_id` out ROB: entry ID allocated this cycle; equals the tail pointer; combinational.
- `busy` out 1: buffer full; dispatch is refused.
- `wb_e_` in 1: writeback, active-low.
- `wb_rob_id` in ROB: entry that completed.
- `commit_e_` out 1: head entry retires this cycle, active-low.
- `commit_rd` out `RegFile_t`: architectural destination of the retiring entry.
- `commit_rob_id` out ROB: ID of the retiring entry; equals the head pointer.

## Operation
- **State**
  - Per entry: `valid`, `done`, `rd`.
  - Pointers `head` and `tail`, each ROB bits wide; they wrap modulo ROB_DEPTH naturally.
  - `count`, ROB+1 bits wide, range 0..ROB_DEPTH.
- **Dispatch**: accepted when `dec_e_ == Enable_ && !busy`.
  - Entry[tail] gets valid=1, done=0, rd=`dec_rd`.
  - tail increments.
  - A dispatch while busy is ignored; the sender must hold and retry.
- **Writeback**: when `wb_e_ == Enable_` and entry[wb_rob_id].valid, set done=1.
  - Writeback to an invalid entry is ignored.
  - A repeated writeback is harmless.
- **Commit**: `commit_e_ = Enable_` iff entry[head].valid && entry[head].done. Commit is combinational from registered state.
  - At the next edge, entry[head].valid is cleared and head increments.
  - At most one commit per cycle.
- **busy** = (count == ROB_DEPTH). It is computed from registered count only; a same-cycle commit does not free a slot for a same-cycle dispatch.
- **count** update: +1 on an accepted dispatch, −1 on commit, unchanged when both occur.
- **Flush**: when `flush_ == Enable_`:
  - All valid and done bits clear; head = tail = 0; count = 0.
  - Flush overrides dispatch, writeback and commit in the same cycle.
  - `commit_e_` still reflects pre-flush state combinationally; the downstream consumer qualifies commit with flush.
- **Reset values**:
  - All valid/done bits = 0; head = tail = count = 0.
  - Outputs: `commit_e_` = `Disable_`, `busy` = 0, `dec_rob_id` = 0, `commit_rob_id` = 0.
  - `commit_rd` = entry[0].rd, which resets to 0.

## Timing
- Allocation has zero latency: `dec_rob_id` is valid in the same cycle as `dec_e_`.
- Writeback at edge N makes `commit_e_` assert in cycle N+1 if that entry is the head.
- Back-to-back retirement: one entry per cycle while consecutive head entries are done.
- Dispatch and writeback to the newly allocated ID in the same cycle is not possible; the writer must wait at least one cycle.
- Wrap-around:
  - After ROB_DEPTH allocations, tail returns to 0.
  - head == tail is disambiguated by count (0 = empty, ROB_DEPTH = full).

## Structure
- The shared `cpu_config.svh`/`regfile.svh` headers hold `RobDepth` and `RegFile_t`.
- Add a `RobEntry_t` struct (valid, done, rd) to a new `rob.svh`.
- Entry storage is a flat register array inside the module; no sub-module is needed.
- Optional sub-module: `rob_ptr`, a wrapping pointer/counter, instanced twice for head and tail.

## Test plan
Use ROB_DEPTH=16 unless noted.
- **Basic**: dispatch rd=GPR 5 → `dec_rob_id`=0; writeback id 0 → next cycle `commit_e_` low, `commit_rd`=GPR 5, `commit_rob_id`=0; then the buffer is empty.
- **In-order**: dispatch ids 0,1,2; writeback 2 then 1 → no commit; writeback 0 → commits 0,1,2 on three consecutive cycles.
- **Full**: 16 dispatches → `busy`=1 and a 17th `dec_e_` is ignored (tail stays 0). Then commit id 0 while dispatching → the dispatch is refused that cycle and accepted the next with id 0.
- **Wrap-around**: alternate dispatch/writeback/commit 40 times → IDs run 0..15,0..15,0..7 and `count` never exceeds 1.
- **Flush**: 5 entries in flight, 2 done, assert `flush_` → next cycle `commit_e_` high, count 0, next dispatch gets id 0; a writeback to old id 3 is ignored.
- **Async reset**: assert `reset_` mid-cycle with entries done → `commit_e_` and `busy` deassert immediately, without waiting for a clock.
